// File: rtl/usb_buffer_arbiter.sv
// Shared USB packet buffer with RX/TX session ownership and single-byte AHB access.
// Optional watermark pulse output enabled by defining USB_BUF_WATERMARK_EN.
module usb_buffer_arbiter #(
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 6,
    parameter int WATERMARK = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              buffer_clear,
    input  logic              rx_start,
    input  logic              rx_end,
    input  logic              rx_wr_req,
    input  logic [7:0]        rx_wr_data,
    output logic              rx_wr_gnt,
    input  logic              tx_start,
    input  logic              tx_end,
    input  logic              tx_rd_req,
    output logic              tx_rd_gnt,
    input  logic              ahb_wr_req,
    input  logic              ahb_rd_req,
    input  logic [7:0]        ahb_wr_data,
    output logic              ahb_gnt,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   occupancy,
    output logic              full,
    output logic              empty,
`ifdef USB_BUF_WATERMARK_EN
    output logic              watermark_hit,
`endif
    output logic              overflow_err,
    output logic              underflow_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RX_OWN  = 2'd1,
        ST_TX_OWN  = 2'd2,
        ST_AHB_OWN = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] LP_FULL = (ADDR_W+1)'(DEPTH);

    if ((1 << ADDR_W) != DEPTH || WATERMARK < 1 || WATERMARK > DEPTH) begin : g_param_err
        $error("usb_buffer_arbiter: inconsistent DEPTH/ADDR_W/WATERMARK");
    end

    logic [7:0]        r_mem [DEPTH];
    state_t            r_state;
    state_t            w_state_next;
    logic              r_ahb_wr;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_occ;
    logic [7:0]        r_rd_data;
    logic              r_rd_valid;
    logic              r_ovf;
    logic              r_unf;

    logic              w_rx_gnt;
    logic              w_tx_gnt;
    logic              w_ahb_gnt;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic [7:0]        w_wr_data;
    logic              w_full;
    logic              w_empty;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (rx_start)
                    w_state_next = ST_RX_OWN;
                else if (tx_start)
                    w_state_next = ST_TX_OWN;
                else if (ahb_wr_req || ahb_rd_req)
                    w_state_next = ST_AHB_OWN;
            end
            ST_RX_OWN:  if (rx_end) w_state_next = ST_IDLE;
            ST_TX_OWN:  if (tx_end) w_state_next = ST_IDLE;
            ST_AHB_OWN: w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
        // A flush aborts whatever session is in progress.
        if (buffer_clear)
            w_state_next = ST_IDLE;
    end

    // Grants are combinational so a requester sees acceptance in the same cycle.
    always_comb begin
        w_rx_gnt  = 1'b0;
        w_tx_gnt  = 1'b0;
        w_ahb_gnt = 1'b0;
        if (!rst && !buffer_clear) begin
            w_rx_gnt  = (r_state == ST_RX_OWN) && rx_wr_req;
            w_tx_gnt  = (r_state == ST_TX_OWN) && tx_rd_req;
            w_ahb_gnt = (r_state == ST_AHB_OWN);
        end
    end

    always_comb begin
        w_full    = (r_occ == LP_FULL);
        w_empty   = (r_occ == '0);
        w_wr_en   = w_rx_gnt || (w_ahb_gnt && r_ahb_wr);
        w_rd_en   = w_tx_gnt || (w_ahb_gnt && !r_ahb_wr);
        w_wr_data = w_rx_gnt ? rx_wr_data : ahb_wr_data;
        w_wr_ok   = w_wr_en && !w_full;
        w_rd_ok   = w_rd_en && !w_empty;
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok)
            r_mem[r_wr_ptr] <= w_wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ahb_wr   <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rd_valid <= w_rd_en;
            // The AHB direction is frozen when ownership is taken; write wins a tie.
            if (r_state == ST_IDLE)
                r_ahb_wr <= ahb_wr_req;
            if (w_rd_en)
                r_rd_data <= w_rd_ok ? r_mem[r_rd_ptr] : 8'h00;
            if (buffer_clear) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_occ    <= '0;
                r_ovf    <= 1'b0;
                r_unf    <= 1'b0;
            end else begin
                if (w_wr_ok) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_occ    <= r_occ + 1'b1;
                end else if (w_wr_en) begin
                    r_ovf <= 1'b1;
                end
                if (w_rd_ok) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_occ    <= r_occ - 1'b1;
                end else if (w_rd_en) begin
                    r_unf <= 1'b1;
                end
            end
        end
    end

`ifdef USB_BUF_WATERMARK_EN
    localparam logic [ADDR_W:0] LP_WM_PRE = (ADDR_W+1)'(WATERMARK - 1);
    logic r_wm_hit;

    // Only an upward crossing by a write counts; reaching the level by reading down does not.
    always_ff @(posedge clk) begin
        if (rst)
            r_wm_hit <= 1'b0;
        else
            r_wm_hit <= w_wr_ok && (r_occ == LP_WM_PRE);
    end

    assign watermark_hit = r_wm_hit;
`endif

    assign rx_wr_gnt     = w_rx_gnt;
    assign tx_rd_gnt     = w_tx_gnt;
    assign ahb_gnt       = w_ahb_gnt;
    assign rd_data       = r_rd_data;
    assign rd_valid      = r_rd_valid;
    assign occupancy     = r_occ;
    assign full          = w_full;
    assign empty         = w_empty;
    assign overflow_err  = r_ovf;
    assign underflow_err = r_unf;

endmodule

// File: tb/tb_usb_buffer_arbiter.sv
// Self-checking bench for usb_buffer_arbiter: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_usb_buffer_arbiter;

    logic       clk = 1'b0;
    logic       rst, buffer_clear;
    logic       rx_start, rx_end, rx_wr_req;
    logic [7:0] rx_wr_data;
    logic       tx_start, tx_end, tx_rd_req;
    logic       ahb_wr_req, ahb_rd_req;
    logic [7:0] ahb_wr_data;
    logic       rx_wr_gnt, tx_rd_gnt, ahb_gnt;
    logic [7:0] rd_data;
    logic       rd_valid, full, empty, overflow_err, underflow_err;
    logic [6:0] occupancy;
`ifdef USB_BUF_WATERMARK_EN
    logic       watermark_hit;
`endif

    int checks = 0;
    int errors = 0;

    usb_buffer_arbiter #(.DEPTH(64), .ADDR_W(6), .WATERMARK(32)) dut (
        .clk(clk), .rst(rst), .buffer_clear(buffer_clear),
        .rx_start(rx_start), .rx_end(rx_end), .rx_wr_req(rx_wr_req),
        .rx_wr_data(rx_wr_data), .rx_wr_gnt(rx_wr_gnt),
        .tx_start(tx_start), .tx_end(tx_end), .tx_rd_req(tx_rd_req),
        .tx_rd_gnt(tx_rd_gnt),
        .ahb_wr_req(ahb_wr_req), .ahb_rd_req(ahb_rd_req),
        .ahb_wr_data(ahb_wr_data), .ahb_gnt(ahb_gnt),
        .rd_data(rd_data), .rd_valid(rd_valid), .occupancy(occupancy),
        .full(full), .empty(empty),
`ifdef USB_BUF_WATERMARK_EN
        .watermark_hit(watermark_hit),
`endif
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Owner: 0 none, 1 RX session, 2 TX session, 3 one-shot AHB slot.
    logic       mdl_valid = 1'b0;
    byte unsigned q[$];
    int         m_own = 0;
    logic       m_ahb_wr = 1'b0;
    logic       m_ovf = 1'b0, m_unf = 1'b0, m_rdv = 1'b0, m_wm = 1'b0;
    logic [7:0] m_rdd = 8'h00;

    initial forever begin
        logic e_rx, e_tx, e_ahb, do_wr, do_rd;
        logic [7:0] wd;
        @(negedge clk);
        e_rx  = !rst && !buffer_clear && m_own == 1 && rx_wr_req;
        e_tx  = !rst && !buffer_clear && m_own == 2 && tx_rd_req;
        e_ahb = !rst && !buffer_clear && m_own == 3;
        if (mdl_valid) begin
            chk("m_rx_wr_gnt", rx_wr_gnt, e_rx);
            chk("m_tx_rd_gnt", tx_rd_gnt, e_tx);
            chk("m_ahb_gnt", ahb_gnt, e_ahb);
            chk("m_rd_data", rd_data, m_rdd);
            chk("m_rd_valid", rd_valid, m_rdv);
            chk("m_occupancy", occupancy, q.size());
            chk("m_full", full, q.size() == 64);
            chk("m_empty", empty, q.size() == 0);
            chk("m_overflow_err", overflow_err, m_ovf);
            chk("m_underflow_err", underflow_err, m_unf);
`ifdef USB_BUF_WATERMARK_EN
            chk("m_watermark_hit", watermark_hit, m_wm);
`endif
        end
        if (rst) begin
            q.delete();
            m_own = 0; m_ahb_wr = 1'b0;
            m_ovf = 1'b0; m_unf = 1'b0; m_rdv = 1'b0; m_rdd = 8'h00; m_wm = 1'b0;
            mdl_valid = 1'b1;
        end else begin
            do_wr = e_rx || (e_ahb && m_ahb_wr);
            do_rd = e_tx || (e_ahb && !m_ahb_wr);
            wd    = e_rx ? rx_wr_data : ahb_wr_data;
            m_wm  = 1'b0;
            m_rdv = do_rd;
            if (buffer_clear) begin
                q.delete();
                m_ovf = 1'b0; m_unf = 1'b0;
            end
            if (do_wr) begin
                if (q.size() == 64) m_ovf = 1'b1;
                else begin
                    if (q.size() == 31) m_wm = 1'b1;
                    q.push_back(wd);
                end
            end
            if (do_rd) begin
                if (q.size() == 0) begin m_rdd = 8'h00; m_unf = 1'b1; end
                else m_rdd = q.pop_front();
            end
            if (buffer_clear) m_own = 0;
            else case (m_own)
                0: begin
                    m_ahb_wr = ahb_wr_req;
                    if (rx_start) m_own = 1;
                    else if (tx_start) m_own = 2;
                    else if (ahb_wr_req || ahb_rd_req) m_own = 3;
                end
                1: if (rx_end) m_own = 0;
                2: if (tx_end) m_own = 0;
                default: m_own = 0;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        buffer_clear = 0; rx_start = 0; rx_end = 0; rx_wr_req = 0; rx_wr_data = 8'h00;
        tx_start = 0; tx_end = 0; tx_rd_req = 0;
        ahb_wr_req = 0; ahb_rd_req = 0; ahb_wr_data = 8'h00;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        step(); step();
        rst = 0;
        @(negedge clk);
        chk("reset_occupancy", occupancy, 0);
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);
        chk("reset_gnts", {rx_wr_gnt, tx_rd_gnt, ahb_gnt}, 0);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_rd_data", rd_data, 8'h00);
        chk("reset_errs", {overflow_err, underflow_err}, 0);
        step();

        // RX session of four bytes, rx_end with the last write
        rx_start = 1; step();
        for (int i = 0; i < 4; i++) begin
            idle_inputs(); rx_wr_req = 1; rx_wr_data = 8'h11 + 8'(i); rx_end = (i == 3);
            @(negedge clk); chk("rx_gnt", rx_wr_gnt, 1); step();
        end
        idle_inputs(); @(negedge clk); chk("rx_occupancy", occupancy, 4); step();

        // TX session reads them back one cycle after each grant
        tx_start = 1; step();
        for (int i = 0; i < 4; i++) begin
            idle_inputs(); tx_rd_req = 1; tx_end = (i == 3);
            @(negedge clk);
            chk("tx_gnt", tx_rd_gnt, 1);
            if (i > 0) begin
                chk("tx_rd_data", rd_data, 8'h11 + 8'(i - 1));
                chk("tx_rd_valid", rd_valid, 1);
            end
            step();
        end
        idle_inputs(); @(negedge clk);
        chk("tx_rd_data_last", rd_data, 8'h14);
        chk("tx_rd_valid_last", rd_valid, 1);
        chk("tx_empty", empty, 1);
        step();

        // Fill, overflow, drain, wrap
        rx_start = 1; step();
        for (int i = 0; i < 64; i++) begin
            idle_inputs(); rx_wr_req = 1; rx_wr_data = 8'(i); step();
        end
        idle_inputs(); rx_wr_req = 1; rx_wr_data = 8'hEE; rx_end = 1;
        @(negedge clk);
        chk("full_flag", full, 1);
        chk("full_occupancy", occupancy, 64);
        chk("ovf_gnt", rx_wr_gnt, 1);
        step();
        idle_inputs(); @(negedge clk);
        chk("ovf_err", overflow_err, 1);
        chk("ovf_occupancy", occupancy, 64);
        step();
        tx_start = 1; step();
        for (int i = 0; i < 64; i++) begin
            idle_inputs(); tx_rd_req = 1; tx_end = (i == 63); step();
        end
        idle_inputs(); @(negedge clk);
        chk("drain_last", rd_data, 8'h3F);
        chk("drain_empty", empty, 1);
        step();
        ahb_wr_req = 1; ahb_wr_data = 8'h5A; step();
        idle_inputs(); ahb_wr_data = 8'h5A;
        @(negedge clk); chk("ahb_wr_gnt", ahb_gnt, 1); step();
        idle_inputs(); @(negedge clk); chk("wrap_occupancy", occupancy, 1); step();
        ahb_rd_req = 1; step();
        idle_inputs(); @(negedge clk); chk("ahb_rd_gnt", ahb_gnt, 1); step();
        @(negedge clk);
        chk("wrap_rd_data", rd_data, 8'h5A);
        chk("wrap_rd_valid", rd_valid, 1);
        step();

        // RX beats a simultaneous AHB write; AHB served once after rx_end
        rx_start = 1; ahb_wr_req = 1; ahb_wr_data = 8'h77; step();
        for (int i = 0; i < 3; i++) begin
            idle_inputs(); ahb_wr_req = 1; ahb_wr_data = 8'h77;
            rx_wr_req = 1; rx_wr_data = 8'h30 + 8'(i); rx_end = (i == 2);
            @(negedge clk);
            chk("arb_ahb_blocked", ahb_gnt, 0);
            chk("arb_rx_gnt", rx_wr_gnt, 1);
            step();
        end
        @(negedge clk); chk("arb_idle_gnt", ahb_gnt, 0); step();
        idle_inputs(); ahb_wr_data = 8'h77;
        @(negedge clk); chk("arb_ahb_gnt", ahb_gnt, 1); step();
        idle_inputs(); @(negedge clk);
        chk("arb_ahb_once", ahb_gnt, 0);
        chk("arb_occupancy", occupancy, 4);
        step();

        // Flush, then underflow via AHB read
        buffer_clear = 1; step();
        idle_inputs(); @(negedge clk); chk("clr_occupancy", occupancy, 0); step();
        ahb_rd_req = 1; step();
        idle_inputs(); @(negedge clk); chk("unf_gnt", ahb_gnt, 1); step();
        @(negedge clk);
        chk("unf_rd_data", rd_data, 8'h00);
        chk("unf_rd_valid", rd_valid, 1);
        chk("unf_err", underflow_err, 1);
        step();

        // Clear mid-RX session
        rx_start = 1; step();
        idle_inputs(); rx_wr_req = 1; rx_wr_data = 8'hA1; step();
        rx_wr_data = 8'hA2; buffer_clear = 1;
        @(negedge clk); chk("clr_rx_gnt", rx_wr_gnt, 0); step();
        idle_inputs(); rx_wr_req = 1; rx_wr_data = 8'hA3;
        @(negedge clk);
        chk("clr_mid_occupancy", occupancy, 0);
        chk("clr_mid_errs", {overflow_err, underflow_err}, 0);
        chk("clr_mid_idle", rx_wr_gnt, 0);
        step();
        idle_inputs();

`ifdef USB_BUF_WATERMARK_EN
        rx_start = 1; step();
        for (int i = 0; i < 32; i++) begin
            idle_inputs(); rx_wr_req = 1; rx_wr_data = 8'(i); rx_end = (i == 31); step();
        end
        idle_inputs(); @(negedge clk);
        chk("wm_hit", watermark_hit, 1);
        chk("wm_occupancy", occupancy, 32);
        step();
        @(negedge clk); chk("wm_single", watermark_hit, 0); step();
        tx_start = 1; step();
        idle_inputs(); tx_rd_req = 1; tx_end = 1; step();
        idle_inputs(); rx_start = 1; step();
        idle_inputs(); rx_wr_req = 1; rx_wr_data = 8'h99; rx_end = 1; step();
        idle_inputs(); @(negedge clk); chk("wm_again", watermark_hit, 1); step();
`endif

        // Random traffic, the model checks every cycle
        for (int n = 0; n < 4000; n++) begin
            rst          = ($urandom_range(0, 499) == 0);
            buffer_clear = ($urandom_range(0, 99) == 0);
            rx_start     = ($urandom_range(0, 19) == 0);
            rx_end       = ($urandom_range(0, 24) == 0);
            tx_start     = ($urandom_range(0, 19) == 0);
            tx_end       = ($urandom_range(0, 24) == 0);
            rx_wr_req    = ($urandom_range(0, 9) < 6);
            tx_rd_req    = ($urandom_range(0, 9) < 6);
            ahb_wr_req   = ($urandom_range(0, 9) < 2);
            ahb_rd_req   = ($urandom_range(0, 9) < 2);
            rx_wr_data   = 8'($urandom);
            ahb_wr_data  = 8'($urandom);
            step();
        end
        rst = 0;
        idle_inputs();
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
